// File: rtl/sat_addsub_acc.sv
// Two-stage signed saturating add/sub/accumulate unit with per-result clip flags
// and a sticky saturation-event counter.
module sat_addsub_acc #(
  parameter int unsigned DW    = 14,
  parameter int unsigned CNT_W = 16
) (
  input  logic             aclk,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [DW-1:0]    int1_i,
  input  logic [DW-1:0]    int2_i,
  input  logic             clr_cnt_i,
  output logic [DW-1:0]    dat_o,
  output logic             valid_o,
  output logic             sat_pos_o,
  output logic             sat_neg_o,
  output logic [CNT_W-1:0] sat_cnt_o,
  output logic [DW-1:0]    acc_o
);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [DW-1:0]    SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]    SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clip a DW+1 bit raw result back to DW bits using its two top bits.
  function automatic logic [DW-1:0] sat_val(input logic [DW:0] raw);
    logic [DW-1:0] res;
    case (raw[DW:DW-1])
      2'b01:   res = SAT_MAX;
      2'b10:   res = SAT_MIN;
      default: res = raw[DW-1:0];
    endcase
    return res;
  endfunction

  logic [DW:0]      w_a;
  logic [DW:0]      w_b;
  logic [DW:0]      w_acc_x;
  logic [DW:0]      w_raw;
  mode_e            w_mode;
  logic [DW-1:0]    w_s1_sat;
  logic             w_s1_pos;
  logic             w_s1_neg;

  logic [DW:0]      r_s1_raw;
  logic             r_s1_vld;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    r_dat;
  logic             r_valid;
  logic             r_pos;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  assign w_mode  = mode_e'(mode_i);
  assign w_a     = {int1_i[DW-1], int1_i};
  assign w_b     = {int2_i[DW-1], int2_i};
  assign w_acc_x = {r_acc[DW-1], r_acc};

  // Stage-1 raw result; one guard bit means the sum/difference never wraps.
  always_comb begin
    w_raw = w_a;
    case (w_mode)
      MODE_ADD:  w_raw = w_a + w_b;
      MODE_SUB:  w_raw = w_a - w_b;
      MODE_ACC:  w_raw = w_acc_x + w_a;
      MODE_LOAD: w_raw = w_a;
      default:   w_raw = w_a;
    endcase
  end

  assign w_s1_sat = sat_val(r_s1_raw);
  assign w_s1_pos = (r_s1_raw[DW:DW-1] == 2'b01);
  assign w_s1_neg = (r_s1_raw[DW:DW-1] == 2'b10);

  // Stage 1: capture raw result; accumulator advances here so ACC ops chain.
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      r_s1_raw <= '0;
      r_s1_vld <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_s1_vld <= en_i;
      if (en_i) begin
        r_s1_raw <= w_raw;
        if (w_mode == MODE_ACC || w_mode == MODE_LOAD) begin
          r_acc <= sat_val(w_raw);
        end
      end
    end
  end

  // Stage 2: saturate and flag; data holds across bubbles, flags do not.
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_pos   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_dat <= w_s1_sat;
        r_pos <= w_s1_pos;
        r_neg <= w_s1_neg;
      end else begin
        r_pos <= 1'b0;
        r_neg <= 1'b0;
      end
    end
  end

  // Saturation-event counter; clear wins over a coincident event.
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (r_s1_vld && (w_s1_pos || w_s1_neg) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dat_o     = r_dat;
  assign valid_o   = r_valid;
  assign sat_pos_o = r_pos;
  assign sat_neg_o = r_neg;
  assign sat_cnt_o = r_cnt;
  assign acc_o     = r_acc;

endmodule
